// File: rtl/decode_pkg.sv
// Shared decode-stage definitions: default register-file geometry, opcode
// constants and the architectural address validity check.
package decode_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_e;

  // An address names real storage only if it is in range and is not the
  // hardwired zero register.
  function automatic logic addr_valid(input int unsigned addr,
                                      input int unsigned nregs,
                                      input bit          zero_reg);
    return (addr < nregs) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: tracks registers with a pending writeback, gates issue
// on WAW hazards and keeps a running count of busy registers.
module reg_scoreboard
  import decode_pkg::*;
#(
  parameter  int NREGS    = NREGS_DEFAULT,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS),
  localparam int CW       = $clog2(NREGS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_addr,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_addr,
  input  logic             flush,
  output logic             iss_ready,
  output logic [NREGS-1:0] busy,
  output logic [CW-1:0]    busy_count
);

  logic [NREGS-1:0] busy_q;
  logic [CW-1:0]    count_q;
  logic             wb_ok;
  logic             iss_ok;
  logic             wb_same;
  logic             iss_busy;
  logic             set_bit;
  logic             inc;
  logic             clr_bit;

  // A writeback to the issuing register in the same cycle frees the slot, so
  // the new producer may claim it; the bit then simply stays set.
  always_comb begin
    wb_ok     = wb_valid && addr_valid(32'(wb_addr), NREGS, ZERO_REG != 0);
    iss_ok    = addr_valid(32'(iss_addr), NREGS, ZERO_REG != 0);
    wb_same   = wb_valid && (wb_addr == iss_addr);
    iss_busy  = iss_ok && busy_q[iss_addr];
    iss_ready = reset && !flush && (!iss_busy || wb_same);
    set_bit   = iss_valid && iss_ready && iss_ok;
    inc       = set_bit && !busy_q[iss_addr];
    clr_bit   = wb_ok && busy_q[wb_addr] && !(set_bit && wb_same);
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      if (clr_bit) busy_q[wb_addr] <= 1'b0;
      if (set_bit) busy_q[iss_addr] <= 1'b1;
      count_q <= count_q + CW'(inc) - CW'(clr_bit);
    end
  end

  assign busy       = reset ? busy_q  : '0;
  assign busy_count = reset ? count_q : '0;

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file: NUM_RD combinational read ports with writeback
// bypass, one write port, and a busy-bit scoreboard for RAW/WAW detection.
module regfile_scoreboard
  import decode_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEFAULT,
  parameter  int NREGS    = NREGS_DEFAULT,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS),
  localparam int CW       = $clog2(NREGS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   wb_valid,
  input  logic [AW-1:0]          wb_addr,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_addr,
  output logic                   iss_ready,
  input  logic                   flush,
  output logic [CW-1:0]          busy_count
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             wb_ok;

  reg_scoreboard #(
    .NREGS   (NREGS),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .flush     (flush),
    .iss_ready (iss_ready),
    .busy      (busy),
    .busy_count(busy_count)
  );

  assign wb_ok = wb_valid && addr_valid(32'(wb_addr), NREGS, ZERO_REG != 0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wb_ok) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // A matching writeback both supplies the data and hides the busy bit,
  // since the operand is available this very cycle.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (reset && addr_valid(32'(rd_addr[i*AW +: AW]), NREGS, ZERO_REG != 0)) begin
        if (wb_valid && (wb_addr == rd_addr[i*AW +: AW])) begin
          rd_data[i*XLEN +: XLEN] = wb_data;
        end else begin
          rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
        end
        rd_busy[i] = busy[rd_addr[i*AW +: AW]] &&
                     !(wb_valid && (wb_addr == rd_addr[i*AW +: AW]));
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard-driven bench for regfile_scoreboard with NREGS=24: directed
// scenarios with literal expectations, then a random phase against a model.
module tb_regfile_scoreboard;

  localparam int XLEN   = 32;
  localparam int NREGS  = 24;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;
  localparam int CW     = 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic                   wb_valid;
  logic [AW-1:0]          wb_addr;
  logic [XLEN-1:0]        wb_data;
  logic                   iss_valid;
  logic [AW-1:0]          iss_addr;
  logic                   iss_ready;
  logic                   flush;
  logic [CW-1:0]          busy_count;

  typedef enum int {K_RD0, K_RD1, K_BUSY0, K_BUSY1, K_READY, K_COUNT} kind_e;

  string       tag_q[$];
  kind_e       kind_q[$];
  logic [31:0] val_q[$];

  int errors = 0;
  int checks = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  regfile_scoreboard #(
    .XLEN    (XLEN),
    .NREGS   (NREGS),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .flush     (flush),
    .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic wv, input logic [AW-1:0] wa,
                               input logic [XLEN-1:0] wd, input logic iv,
                               input logic [AW-1:0] ia, input logic fl);
    rd_addr   = {a1, a0};
    wb_valid  = wv;
    wb_addr   = wa;
    wb_data   = wd;
    iss_valid = iv;
    iss_addr  = ia;
    flush     = fl;
  endtask

  task automatic push_exp(input kind_e k, input string tag, input logic [31:0] v);
    kind_q.push_back(k);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  function automatic logic [31:0] observe(input kind_e k);
    case (k)
      K_RD0:   return rd_data[31:0];
      K_RD1:   return rd_data[63:32];
      K_BUSY0: return {31'b0, rd_busy[0]};
      K_BUSY1: return {31'b0, rd_busy[1]};
      K_READY: return {31'b0, iss_ready};
      K_COUNT: return {27'b0, busy_count};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic bit m_valid(input logic [AW-1:0] a);
    return (int'(a) < NREGS) && (a != 0);
  endfunction

  function automatic logic [31:0] m_rd(input logic [AW-1:0] a);
    if (!reset || !m_valid(a)) return 32'h0;
    if (wb_valid && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] m_rdbusy(input logic [AW-1:0] a);
    if (!reset || !m_valid(a)) return 32'h0;
    return {31'b0, m_busy[a] && !(wb_valid && wb_addr == a)};
  endfunction

  function automatic bit m_ready();
    if (!reset || flush) return 1'b0;
    return !(m_valid(iss_addr) && m_busy[iss_addr]) || (wb_valid && wb_addr == iss_addr);
  endfunction

  function automatic logic [31:0] m_count();
    int n = 0;
    if (!reset) return 32'h0;
    for (int r = 0; r < NREGS; r++) n += int'(m_busy[r]);
    return 32'(n);
  endfunction

  task automatic model_commit();
    bit rdy;
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
      return;
    end
    rdy = m_ready();
    if (wb_valid && m_valid(wb_addr)) begin
      m_regs[wb_addr] = wb_data;
      m_busy[wb_addr] = 1'b0;
    end
    if (iss_valid && rdy && m_valid(iss_addr)) m_busy[iss_addr] = 1'b1;
    if (flush) for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
  endtask

  task automatic expect_all(input string pre);
    push_exp(K_RD0,   {pre, "_rd0"},   m_rd(rd_addr[AW-1:0]));
    push_exp(K_RD1,   {pre, "_rd1"},   m_rd(rd_addr[2*AW-1:AW]));
    push_exp(K_BUSY0, {pre, "_busy0"}, m_rdbusy(rd_addr[AW-1:0]));
    push_exp(K_BUSY1, {pre, "_busy1"}, m_rdbusy(rd_addr[2*AW-1:AW]));
    push_exp(K_READY, {pre, "_ready"}, {31'b0, m_ready()});
    push_exp(K_COUNT, {pre, "_count"}, m_count());
  endtask

  // Pops and compares every queued expectation just before the edge, then
  // advances the model and the DUT together; starts and ends on a negedge.
  task automatic cycle();
    #3;
    while (kind_q.size() > 0) begin
      kind_e       k;
      string       t;
      logic [31:0] v;
      k = kind_q.pop_front();
      t = tag_q.pop_front();
      v = val_q.pop_front();
      checkOutput(t, observe(k), v);
    end
    model_commit();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(5, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    push_exp(K_COUNT, "init_count", 0);
    push_exp(K_READY, "init_ready", 0);
    cycle();
    reset = 1'b1;

    // Reset clears stored data
    applyStimulus(5, 0, 1, 5, 32'hDEAD, 0, 0, 0);
    push_exp(K_RD0, "wr5_bypass", 32'hDEAD);
    cycle();
    applyStimulus(5, 0, 0, 0, 0, 0, 0, 0);
    push_exp(K_RD0, "wr5_stored", 32'hDEAD);
    cycle();
    reset = 1'b0;
    push_exp(K_RD0, "in_reset_rd0", 0);
    push_exp(K_READY, "in_reset_ready", 0);
    push_exp(K_COUNT, "in_reset_count", 0);
    cycle();
    reset = 1'b1;
    push_exp(K_RD0, "post_reset_rd0", 0);
    push_exp(K_COUNT, "post_reset_count", 0);
    push_exp(K_READY, "post_reset_ready", 1);
    cycle();

    // Bypass on port 1
    applyStimulus(0, 3, 1, 3, 32'h1234, 0, 0, 0);
    push_exp(K_RD1, "bypass_rd1", 32'h1234);
    cycle();
    applyStimulus(0, 3, 0, 0, 0, 0, 0, 0);
    push_exp(K_RD1, "stored_rd1", 32'h1234);
    cycle();

    // RAW hazard on x7
    applyStimulus(0, 0, 0, 0, 0, 1, 7, 0);
    push_exp(K_READY, "raw_iss_ready", 1);
    cycle();
    applyStimulus(7, 0, 0, 0, 0, 0, 0, 0);
    push_exp(K_BUSY0, "raw_busy", 1);
    push_exp(K_COUNT, "raw_count1", 1);
    cycle();
    applyStimulus(7, 0, 1, 7, 32'h55, 0, 0, 0);
    push_exp(K_BUSY0, "raw_wb_busy", 0);
    push_exp(K_RD0, "raw_wb_data", 32'h55);
    cycle();
    applyStimulus(7, 0, 0, 0, 0, 0, 0, 0);
    push_exp(K_COUNT, "raw_count0", 0);
    push_exp(K_RD0, "raw_stored", 32'h55);
    cycle();

    // WAW stall on x9
    applyStimulus(0, 0, 0, 0, 0, 1, 9, 0);
    cycle();
    applyStimulus(9, 0, 0, 0, 0, 1, 9, 0);
    push_exp(K_READY, "waw_stall", 0);
    push_exp(K_COUNT, "waw_count", 1);
    cycle();
    applyStimulus(9, 0, 1, 9, 32'hAA, 1, 9, 0);
    push_exp(K_READY, "waw_wb_ready", 1);
    cycle();
    applyStimulus(9, 0, 0, 0, 0, 0, 0, 0);
    push_exp(K_BUSY0, "waw_still_busy", 1);
    push_exp(K_COUNT, "waw_count_same", 1);
    cycle();

    // x0 and out-of-range addresses
    applyStimulus(0, 0, 1, 0, 32'hFF, 0, 0, 0);
    push_exp(K_RD0, "x0_bypass", 0);
    cycle();
    applyStimulus(0, 30, 0, 0, 0, 1, 0, 0);
    push_exp(K_RD0, "x0_read", 0);
    push_exp(K_READY, "x0_iss_ready", 1);
    push_exp(K_RD1, "x30_rd", 0);
    push_exp(K_BUSY1, "x30_busy", 0);
    cycle();
    applyStimulus(0, 30, 0, 0, 0, 1, 30, 0);
    push_exp(K_BUSY0, "x0_not_busy", 0);
    push_exp(K_COUNT, "x0_count", 1);
    push_exp(K_READY, "x30_iss_ready", 1);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    push_exp(K_COUNT, "x30_count", 1);
    cycle();

    // Flush with coincident writeback and issue
    applyStimulus(0, 0, 0, 0, 0, 1, 4, 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 11, 0);
    cycle();
    applyStimulus(4, 0, 1, 4, 32'h77, 1, 12, 1);
    push_exp(K_COUNT, "pre_flush_count", 3);
    push_exp(K_READY, "flush_ready", 0);
    push_exp(K_RD0, "flush_bypass", 32'h77);
    cycle();
    applyStimulus(4, 12, 0, 0, 0, 0, 0, 0);
    push_exp(K_COUNT, "flush_count", 0);
    push_exp(K_RD0, "flush_stored", 32'h77);
    push_exp(K_BUSY1, "flush_x12_busy", 0);
    cycle();

    // Random traffic checked against the model
    for (int n = 0; n < 200; n++) begin
      applyStimulus(5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 25)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 25)),
                    ($urandom_range(0, 15) == 0));
      expect_all($sformatf("rnd%0d", n));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
